test_sequencer: RTL and testbench

- Synthesizable successor to the simulation top-level that runs sub-benches one after another.
- Runs NUM_TESTS self-test channels strictly in order, each through a start/done handshake.
- Applies a per-test watchdog timeout and collects pass, fail and timeout status per channel.
- Used in both the simulation top and the FPGA self-test path; its results are read out over SPI.

---
 rtl/test_sequencer.sv | 143 ++++++++++++++
 tb/tb_test_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_sequencer.sv
// Runs NUM_TESTS self-test channels in order via start/done handshakes, with a per-channel watchdog.
// Optional macro TEST_SEQUENCER_STOP_ON_FAIL_EN ends the sequence at the first fail or timeout.
module test_sequencer #(
  parameter int NUM_TESTS      = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int IDX_W          = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 run_i,
  input  logic [NUM_TESTS-1:0] skip_mask_i,
  output logic [NUM_TESTS-1:0] test_start_o,
  input  logic [NUM_TESTS-1:0] test_done_i,
  input  logic [NUM_TESTS-1:0] test_pass_i,
  output logic                 busy_o,
  output logic                 complete_o,
  output logic [IDX_W-1:0]     current_o,
  output logic [NUM_TESTS-1:0] pass_mask_o,
  output logic [NUM_TESTS-1:0] fail_mask_o,
  output logic [NUM_TESTS-1:0] timeout_mask_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TESTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_WAIT,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t               r_state, w_nextState;
  logic [IDX_W-1:0]     r_idx, w_nextIdx;
  logic [WD_W-1:0]      r_wd, w_nextWd;
  logic [NUM_TESTS-1:0] r_skip, w_nextSkip;
  logic [NUM_TESTS-1:0] r_start, w_nextStart;
  logic [NUM_TESTS-1:0] r_pass, w_nextPass;
  logic [NUM_TESTS-1:0] r_fail, w_nextFail;
  logic [NUM_TESTS-1:0] r_timeout, w_nextTimeout;
  logic                 w_doneSeen;
  logic                 w_stop;

  // The start pulse is registered, so it overlaps the first WAIT cycle; done is ignored there.
  assign w_doneSeen = test_done_i[r_idx] && (r_start == '0);

`ifdef TEST_SEQUENCER_STOP_ON_FAIL_EN
  assign w_stop = r_fail[r_idx] | r_timeout[r_idx];
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_wd      <= '0;
      r_skip    <= '0;
      r_start   <= '0;
      r_pass    <= '0;
      r_fail    <= '0;
      r_timeout <= '0;
    end else begin
      r_state   <= w_nextState;
      r_idx     <= w_nextIdx;
      r_wd      <= w_nextWd;
      r_skip    <= w_nextSkip;
      r_start   <= w_nextStart;
      r_pass    <= w_nextPass;
      r_fail    <= w_nextFail;
      r_timeout <= w_nextTimeout;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextIdx     = r_idx;
    w_nextWd      = r_wd;
    w_nextSkip    = r_skip;
    w_nextStart   = '0;
    w_nextPass    = r_pass;
    w_nextFail    = r_fail;
    w_nextTimeout = r_timeout;
    case (r_state)
      S_IDLE: begin
        if (run_i) begin
          w_nextSkip    = skip_mask_i;
          w_nextPass    = '0;
          w_nextFail    = '0;
          w_nextTimeout = '0;
          w_nextIdx     = '0;
          w_nextState   = S_SELECT;
        end
      end
      S_SELECT: begin
        if (r_skip[r_idx]) begin
          w_nextState = S_NEXT;
        end else begin
          w_nextStart[r_idx] = 1'b1;
          w_nextWd           = '0;
          w_nextState        = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_doneSeen) begin
          w_nextPass[r_idx] = test_pass_i[r_idx];
          w_nextFail[r_idx] = ~test_pass_i[r_idx];
          w_nextState       = S_NEXT;
        end else if (r_wd == WD_LAST) begin
          w_nextTimeout[r_idx] = 1'b1;
          w_nextState          = S_NEXT;
        end else begin
          w_nextWd = r_wd + 1'b1;
        end
      end
      S_NEXT: begin
        if (w_stop || (r_idx == IDX_LAST)) begin
          w_nextState = S_FINISH;
        end else begin
          w_nextIdx   = r_idx + 1'b1;
          w_nextState = S_SELECT;
        end
      end
      S_FINISH: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  assign test_start_o   = r_start;
  assign busy_o         = (r_state == S_SELECT) || (r_state == S_WAIT) || (r_state == S_NEXT);
  assign complete_o     = (r_state == S_FINISH);
  assign current_o      = r_idx;
  assign pass_mask_o    = r_pass;
  assign fail_mask_o    = r_fail;
  assign timeout_mask_o = r_timeout;

endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer: stimulus queues expected events, a monitor pops and checks them.
module tb_test_sequencer;
  localparam int N  = 4;
  localparam int TO = 16;

  logic         clock_i = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         run_i = 1'b0;
  logic [N-1:0] skip_mask_i = '0;
  logic [N-1:0] test_done_i = '0;
  logic [N-1:0] test_pass_i = '0;
  logic [N-1:0] test_start_o;
  logic         busy_o;
  logic         complete_o;
  logic [1:0]   current_o;
  logic [N-1:0] pass_mask_o;
  logic [N-1:0] fail_mask_o;
  logic [N-1:0] timeout_mask_o;

  test_sequencer #(.NUM_TESTS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .run_i(run_i), .skip_mask_i(skip_mask_i),
    .test_start_o(test_start_o), .test_done_i(test_done_i), .test_pass_i(test_pass_i),
    .busy_o(busy_o), .complete_o(complete_o), .current_o(current_o),
    .pass_mask_o(pass_mask_o), .fail_mask_o(fail_mask_o), .timeout_mask_o(timeout_mask_o)
  );

  always #5 clock_i = ~clock_i;

  // kind: 0 = start pulse, 1 = mask change, 2 = complete; gap = cycles since previous event or run
  typedef struct {
    int         kind;
    logic [N-1:0] start;
    logic [N-1:0] pass;
    logic [N-1:0] fail;
    logic [N-1:0] tmo;
    logic [1:0] cur;
    int         gap;
  } ev_t;

  ev_t expQ[$];
  int nVectors = 0;
  int nMiscompares = 0;
  int cycleCount = 0;
  int lastEvCycle = 0;
  int runMark = 0;
  int doneDelay[N];
  int cnt[N];
  logic [N-1:0] passVec = '1;
  int ghostFor = -1;
  int ghostCh = 0;
  logic [3*N-1:0] prevMasks = '0;

  always @(posedge clock_i) cycleCount++;

  // Channel model: done pulses doneDelay cycles after the start pulse (negative = never)
  task automatic fire(input int c);
    test_done_i[c] = 1'b1;
    test_pass_i[c] = passVec[c];
    if (ghostFor == c) begin
      test_done_i[ghostCh] = 1'b1;
      test_pass_i[ghostCh] = 1'b1;
    end
  endtask

  always @(negedge clock_i) begin
    test_done_i = '0;
    test_pass_i = '0;
    for (int c = 0; c < N; c++) begin
      if (!reset_n_i) begin
        cnt[c] = 0;
      end else if (cnt[c] > 0) begin
        cnt[c] = cnt[c] - 1;
        if (cnt[c] == 0) fire(c);
      end else if (test_start_o[c]) begin
        if (doneDelay[c] == 0) fire(c);
        else if (doneDelay[c] > 0) cnt[c] = doneDelay[c];
      end
    end
  end

  task automatic observe(input int kind);
    ev_t e;
    int gap;
    int base;
    bit ok;
    base = (runMark >= lastEvCycle) ? runMark : lastEvCycle;
    gap = cycleCount - base;
    nVectors++;
    if (expQ.size() == 0) begin
      nMiscompares++;
      $display("[TB] FAIL event: got kind=%0d start=%b pass=%b fail=%b tmo=%b cur=%0d gap=%0d, required no event",
               kind, test_start_o, pass_mask_o, fail_mask_o, timeout_mask_o, current_o, gap);
    end else begin
      e = expQ.pop_front();
      ok = (e.kind == kind);
      if (e.kind == 0) ok = ok && (test_start_o == e.start);
      if (e.kind >= 1) ok = ok && (pass_mask_o == e.pass) && (fail_mask_o == e.fail) && (timeout_mask_o == e.tmo);
      if (e.kind == 2) ok = ok && (current_o == e.cur);
      if (e.gap >= 0) ok = ok && (gap == e.gap);
      if (!ok) begin
        nMiscompares++;
        $display("[TB] FAIL event: got kind=%0d start=%b pass=%b fail=%b tmo=%b cur=%0d gap=%0d, required kind=%0d start=%b pass=%b fail=%b tmo=%b cur=%0d gap=%0d",
                 kind, test_start_o, pass_mask_o, fail_mask_o, timeout_mask_o, current_o, gap,
                 e.kind, e.start, e.pass, e.fail, e.tmo, e.cur, e.gap);
      end
    end
    lastEvCycle = cycleCount;
  endtask

  always @(negedge clock_i) begin
    if (reset_n_i) begin
      if ({pass_mask_o, fail_mask_o, timeout_mask_o} != prevMasks &&
          {pass_mask_o, fail_mask_o, timeout_mask_o} != '0) observe(1);
      if (test_start_o != '0) observe(0);
      if (complete_o) observe(2);
    end
    prevMasks = {pass_mask_o, fail_mask_o, timeout_mask_o};
  end

  task automatic expectEv(input int kind, input logic [N-1:0] st, input logic [N-1:0] p,
                          input logic [N-1:0] f, input logic [N-1:0] t, input logic [1:0] cur,
                          input int gap);
    ev_t e;
    e.kind = kind; e.start = st; e.pass = p; e.fail = f; e.tmo = t; e.cur = cur; e.gap = gap;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nVectors++;
    if (act !== req) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " start"}, 32'(test_start_o), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, " complete"}, 32'(complete_o), 32'd0);
    checkOutput({tag, " current"}, 32'(current_o), 32'd0);
    checkOutput({tag, " pass"}, 32'(pass_mask_o), 32'd0);
    checkOutput({tag, " fail"}, 32'(fail_mask_o), 32'd0);
    checkOutput({tag, " timeout"}, 32'(timeout_mask_o), 32'd0);
  endtask

  task automatic setDelays(input int d0, input int d1, input int d2, input int d3);
    doneDelay[0] = d0; doneDelay[1] = d1; doneDelay[2] = d2; doneDelay[3] = d3;
  endtask

  task automatic applyStimulus(input logic [N-1:0] skip);
    @(negedge clock_i);
    skip_mask_i = skip;
    run_i = 1'b1;
    runMark = cycleCount;
    @(negedge clock_i);
    run_i = 1'b0;
  endtask

  task automatic waitIdle();
    bit drained = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock_i);
      if (expQ.size() == 0 && !busy_o && !complete_o) begin
        drained = 1;
        break;
      end
    end
    nVectors++;
    if (!drained) begin
      nMiscompares++;
      $display("[TB] FAIL drain: got %0d pending events required 0", expQ.size());
      expQ.delete();
    end
    repeat (3) @(negedge clock_i);
  endtask

  // Every channel passes 5 cycles after its start
  task automatic expectAllPass();
    logic [N-1:0] one;
    logic [N-1:0] acc;
    acc = '0;
    for (int c = 0; c < N; c++) begin
      one = 4'b0001 << c;
      acc = acc | one;
      expectEv(0, one, 0, 0, 0, 0, 2);
      expectEv(1, 0, acc, 0, 0, 0, 6);
    end
    expectEv(2, 0, 4'b1111, 0, 0, 2'd3, 1);
  endtask

  initial begin
    bit seen;
    setDelays(5, 5, 5, 5);
    repeat (3) @(negedge clock_i);
    checkAllZero("reset");
    @(negedge clock_i);
    reset_n_i = 1'b1;

    $display("[TB] all channels pass");
    expectAllPass();
    applyStimulus(4'b0000);
    waitIdle();

    $display("[TB] channel 2 fails");
    passVec = 4'b1011;
    expectEv(0, 4'b0001, 0, 0, 0, 0, 2);
    expectEv(1, 0, 4'b0001, 0, 0, 0, 6);
    expectEv(0, 4'b0010, 0, 0, 0, 0, 2);
    expectEv(1, 0, 4'b0011, 0, 0, 0, 6);
    expectEv(0, 4'b0100, 0, 0, 0, 0, 2);
    expectEv(1, 0, 4'b0011, 4'b0100, 0, 0, 6);
`ifdef TEST_SEQUENCER_STOP_ON_FAIL_EN
    expectEv(2, 0, 4'b0011, 4'b0100, 0, 2'd2, 1);
`else
    expectEv(0, 4'b1000, 0, 0, 0, 0, 2);
    expectEv(1, 0, 4'b1011, 4'b0100, 0, 0, 6);
    expectEv(2, 0, 4'b1011, 4'b0100, 0, 2'd3, 1);
`endif
    applyStimulus(4'b0000);
    waitIdle();

    $display("[TB] channel 1 times out");
    passVec = 4'b1111;
    setDelays(5, -1, 5, 5);
    expectEv(0, 4'b0001, 0, 0, 0, 0, 2);
    expectEv(1, 0, 4'b0001, 0, 0, 0, 6);
    expectEv(0, 4'b0010, 0, 0, 0, 0, 2);
    expectEv(1, 0, 4'b0001, 0, 4'b0010, 0, 16);
`ifdef TEST_SEQUENCER_STOP_ON_FAIL_EN
    expectEv(2, 0, 4'b0001, 0, 4'b0010, 2'd1, 1);
`else
    expectEv(0, 4'b0100, 0, 0, 0, 0, 2);
    expectEv(1, 0, 4'b0101, 0, 4'b0010, 0, 6);
    expectEv(0, 4'b1000, 0, 0, 0, 0, 2);
    expectEv(1, 0, 4'b1101, 0, 4'b0010, 0, 6);
    expectEv(2, 0, 4'b1101, 0, 4'b0010, 2'd3, 1);
`endif
    applyStimulus(4'b0000);
    waitIdle();

    $display("[TB] skip masks");
    setDelays(5, 5, 5, 5);
    expectEv(0, 4'b0010, 0, 0, 0, 0, 4);
    expectEv(1, 0, 4'b0010, 0, 0, 0, 6);
    expectEv(0, 4'b1000, 0, 0, 0, 0, 4);
    expectEv(1, 0, 4'b1010, 0, 0, 0, 6);
    expectEv(2, 0, 4'b1010, 0, 0, 2'd3, 1);
    applyStimulus(4'b0101);
    waitIdle();
    expectEv(2, 0, 0, 0, 0, 2'd3, 9);
    applyStimulus(4'b1111);
    waitIdle();

    $display("[TB] done on last watchdog cycle, ghost done, done with start");
    setDelays(5, 15, 0, 5);
    ghostFor = 1;
    ghostCh = 3;
    expectEv(0, 4'b0001, 0, 0, 0, 0, 2);
    expectEv(1, 0, 4'b0001, 0, 0, 0, 6);
    expectEv(0, 4'b0010, 0, 0, 0, 0, 2);
    expectEv(1, 0, 4'b0011, 0, 0, 0, 16);
    expectEv(0, 4'b0100, 0, 0, 0, 0, 2);
    expectEv(1, 0, 4'b0011, 0, 4'b0100, 0, 16);
`ifdef TEST_SEQUENCER_STOP_ON_FAIL_EN
    expectEv(2, 0, 4'b0011, 0, 4'b0100, 2'd2, 1);
`else
    expectEv(2, 0, 4'b0011, 0, 4'b0100, 2'd3, 3);
`endif
    applyStimulus(4'b1000);
    waitIdle();
    ghostFor = -1;

    $display("[TB] reset during channel 2 wait");
    setDelays(5, 5, -1, 5);
    expectEv(0, 4'b0001, 0, 0, 0, 0, 2);
    expectEv(1, 0, 4'b0001, 0, 0, 0, 6);
    expectEv(0, 4'b0010, 0, 0, 0, 0, 2);
    expectEv(1, 0, 4'b0011, 0, 0, 0, 6);
    expectEv(0, 4'b0100, 0, 0, 0, 0, 2);
    applyStimulus(4'b0000);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock_i);
      if (test_start_o == 4'b0100) begin
        seen = 1;
        break;
      end
    end
    checkOutput("reach ch2", 32'(seen), 32'd1);
    repeat (4) @(negedge clock_i);
    #2 reset_n_i = 1'b0;
    #1 checkAllZero("abort");
    repeat (2) @(negedge clock_i);
    reset_n_i = 1'b1;
    setDelays(5, 5, 5, 5);
    waitIdle();
    expectAllPass();
    applyStimulus(4'b0000);
    waitIdle();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end
endmodule
